tile_lock_unit: RTL and testbench

Downstream stage of the current-tile memory. When the falling tile can no longer move down, the game controller pulses `start_i` with the tile's position and 4x4 shape. This block then:
- ORs the shape into the playfield row memory;
- removes every full row by compacting the rows above it downward;
- zero-fills the rows vacated at the top;
- reports the number of lines cleared and whether any cell locked above the visible field (game over).

---
 rtl/tile_lock_unit.sv | 202 ++++++++++++++++++++
 tb/tb_tile_lock_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_lock_unit.sv
// tile_lock_unit: merges a landed 4x4 tile into the playfield row memory,
// removes full rows by compacting the rows above them downward, zero-fills
// the vacated top rows and reports lines cleared plus a game-over flag.

package tile_lock_pkg;

    // Tile origin; both coordinates are two's-complement signed.
    typedef struct packed {
        logic [7:0] x_m;
        logic [7:0] y_m;
    } point_t;

    // shape[r][c] is the cell at column x_m+c, row y_m+r.
    typedef logic [3:0][3:0] shape_t;

endpackage

module tile_lock_unit
    import tile_lock_pkg::*;
#(
    parameter  int width_p       = 10,
    parameter  int height_p      = 20,
    localparam int row_addr_w_lp = $clog2(height_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  point_t                   pos_i,
    input  shape_t                   shape_i,
    output logic                     ready_o,
    output logic [row_addr_w_lp-1:0] row_rd_addr_o,
    input  logic [width_p-1:0]       row_rd_data_i,
    output logic                     row_wr_o,
    output logic [row_addr_w_lp-1:0] row_wr_addr_o,
    output logic [width_p-1:0]       row_wr_data_o,
    output logic                     done_o,
    output logic [2:0]               lines_o,
    output logic                     overflow_o
);

    // Row counters carry one spare bit so they can never wrap silently.
    localparam int cnt_w = row_addr_w_lp + 1;

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        COMPACT,
        FILL,
        DONE
    } state_t;

    state_t               state_q, state_d;
    point_t               pos_q;
    shape_t               shape_q;
    logic [1:0]           r_q, r_d;
    logic [cnt_w-1:0]     src_q, src_d;
    logic [cnt_w-1:0]     dst_q, dst_d;
    logic [2:0]           lines_q, lines_d;
    logic                 overflow_q, overflow_d;

    logic signed [11:0]   x_org;
    logic signed [11:0]   y_row;
    logic                 y_in_field;
    logic [3:0]           shape_row;
    logic [width_p-1:0]   shifted;

    // Place the current shape row at the tile's column offset, dropping
    // cells that land outside the playfield, and locate its target row.
    always_comb begin
        logic signed [11:0] off;
        x_org      = 12'($signed(pos_q.x_m));
        y_row      = 12'($signed(pos_q.y_m)) + {10'b0, r_q};
        y_in_field = (y_row >= 12'sd0) && (y_row < 12'(height_p));
        shape_row  = shape_q[r_q];
        shifted    = '0;
        off        = '0;
        for (int i = 0; i < width_p; i++) begin
            off = 12'(i) - x_org;
            if ((off >= 12'sd0) && (off <= 12'sd3)) begin
                shifted[i] = shape_row[off[1:0]];
            end
        end
    end

    // Next-state logic and memory port control for the lock sequence.
    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        src_d         = src_q;
        dst_d         = dst_q;
        lines_d       = lines_q;
        overflow_d    = overflow_q;
        ready_o       = 1'b0;
        done_o        = 1'b0;
        row_rd_addr_o = '0;
        row_wr_o      = 1'b0;
        row_wr_addr_o = '0;
        row_wr_data_o = '0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d    = MERGE;
                    r_d        = 2'd0;
                    lines_d    = 3'd0;
                    overflow_d = 1'b0;
                end
            end

            MERGE: begin
                row_rd_addr_o = y_row[row_addr_w_lp-1:0];
                if (y_in_field) begin
                    row_wr_o      = 1'b1;
                    row_wr_addr_o = y_row[row_addr_w_lp-1:0];
                    row_wr_data_o = row_rd_data_i | shifted;
                end else if (y_row[11] && (shape_row != 4'd0)) begin
                    overflow_d = 1'b1;
                end
                r_d = r_q + 2'd1;
                if (r_q == 2'd3) begin
                    state_d = COMPACT;
                    src_d   = cnt_w'(height_p - 1);
                    dst_d   = cnt_w'(height_p - 1);
                end
            end

            COMPACT: begin
                row_rd_addr_o = src_q[row_addr_w_lp-1:0];
                if (&row_rd_data_i) begin
                    lines_d = lines_q + 3'd1;
                end else begin
                    if (dst_q != src_q) begin
                        row_wr_o      = 1'b1;
                        row_wr_addr_o = dst_q[row_addr_w_lp-1:0];
                        row_wr_data_o = row_rd_data_i;
                    end
                    if (dst_q != '0) begin
                        dst_d = dst_q - 1'b1;
                    end
                end
                if (src_q == '0) begin
                    state_d = (lines_d != 3'd0) ? FILL : DONE;
                end else begin
                    src_d = src_q - 1'b1;
                end
            end

            FILL: begin
                row_wr_o      = 1'b1;
                row_wr_addr_o = dst_q[row_addr_w_lp-1:0];
                row_wr_data_o = '0;
                if (dst_q == '0) begin
                    state_d = DONE;
                end else begin
                    dst_d = dst_q - 1'b1;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; results are published on entry to DONE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            shape_q    <= '0;
            r_q        <= 2'd0;
            src_q      <= '0;
            dst_q      <= '0;
            lines_q    <= 3'd0;
            overflow_q <= 1'b0;
            lines_o    <= 3'd0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            lines_q    <= lines_d;
            overflow_q <= overflow_d;
            if ((state_q == IDLE) && start_i) begin
                pos_q   <= pos_i;
                shape_q <= shape_i;
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                lines_o    <= lines_d;
                overflow_o <= overflow_d;
            end
        end
    end

endmodule

// File: tb/tb_tile_lock_unit.sv
// Directed testbench for tile_lock_unit with a behavioural row memory.

module tb_tile_lock_unit;
    import tile_lock_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    point_t      pos;
    shape_t      shape;
    logic        ready;
    logic [4:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        row_wr;
    logic [4:0]  wr_addr;
    logic [9:0]  wr_data;
    logic        done;
    logic [2:0]  lines;
    logic        overflow;

    logic        load_en;
    logic [4:0]  load_addr;
    logic [9:0]  load_data;

    logic [9:0]  mem [20];
    int          wr_count = 0;
    int          bad_wr = 0;

    int          n_checks = 0;
    int          n_fail = 0;

    tile_lock_unit #(.width_p(10), .height_p(20)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .pos_i         (pos),
        .shape_i       (shape),
        .ready_o       (ready),
        .row_rd_addr_o (rd_addr),
        .row_rd_data_i (rd_data),
        .row_wr_o      (row_wr),
        .row_wr_addr_o (wr_addr),
        .row_wr_data_o (wr_data),
        .done_o        (done),
        .lines_o       (lines),
        .overflow_o    (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Combinational read port of the playfield memory.
    always_comb begin
        rd_data = (rd_addr < 5'd20) ? mem[rd_addr] : 10'h000;
    end

    // Playfield memory: DUT writes and bench preloads commit on the edge.
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (row_wr) begin
            wr_count <= wr_count + 1;
            if (wr_addr < 5'd20) begin
                mem[wr_addr] <= wr_data;
            end else begin
                bad_wr <= bad_wr + 1;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load_row(input int addr, input logic [9:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 5'(addr);
        load_data = data;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic clear_field();
        for (int i = 0; i < 20; i++) begin
            load_row(i, 10'h000);
        end
    endtask

    // Issue one lock request and wait (bounded) for its done pulse.
    task automatic apply_stimulus(input point_t p, input shape_t s,
                                  output int latency, output logic [2:0] res_lines,
                                  output logic res_ovf);
        bit found;
        found   = 1'b0;
        latency = -1;
        @(negedge clk);
        check_output("ready_before_start", 32'(ready), 32'd1);
        pos   = p;
        shape = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pos   = '{x_m: 8'h05, y_m: 8'h03};
        shape = 16'hFFFF;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (!found && done) begin
                found   = 1'b1;
                latency = n;
                break;
            end
        end
        res_lines = lines;
        res_ovf   = overflow;
        @(negedge clk);
        check_output("done_single_cycle", 32'(done), 32'd0);
        check_output("ready_after_done", 32'(ready), 32'd1);
        check_output("lines_held", 32'(lines), 32'(res_lines));
    endtask

    initial begin
        int         lat;
        logic [2:0] l;
        logic       o;
        int         base;
        int         done_seen;
        int         first_done;

        reset     = 1'b1;
        start     = 1'b0;
        pos       = '0;
        shape     = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ready", 32'(ready), 32'd1);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_wr", 32'(row_wr), 32'd0);
        check_output("reset_lines", 32'(lines), 32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] step 1: O-piece on empty field");
        clear_field();
        base = wr_count;
        apply_stimulus('{x_m: 8'd4, y_m: 8'd18}, 16'h0033, lat, l, o);
        check_output("t1_latency", 32'(lat), 32'd25);
        check_output("t1_lines", 32'(l), 32'd0);
        check_output("t1_ovf", 32'(o), 32'd0);
        check_output("t1_row18", 32'(mem[18]), 32'h030);
        check_output("t1_row19", 32'(mem[19]), 32'h030);
        check_output("t1_writes", 32'(wr_count - base), 32'd2);

        $display("[TB] step 2: single line clear");
        clear_field();
        load_row(19, 10'h3CF);
        load_row(18, 10'h001);
        apply_stimulus('{x_m: 8'd4, y_m: 8'd18}, 16'h0033, lat, l, o);
        check_output("t2_latency", 32'(lat), 32'd26);
        check_output("t2_lines", 32'(l), 32'd1);
        check_output("t2_ovf", 32'(o), 32'd0);
        check_output("t2_row19", 32'(mem[19]), 32'h031);
        check_output("t2_row18", 32'(mem[18]), 32'h000);
        check_output("t2_row0", 32'(mem[0]), 32'h000);

        $display("[TB] step 3: four line clear");
        clear_field();
        for (int i = 16; i < 20; i++) begin
            load_row(i, 10'h3FE);
        end
        load_row(12, 10'h011);
        load_row(13, 10'h022);
        load_row(14, 10'h044);
        load_row(15, 10'h088);
        load_row(0, 10'h200);
        load_row(3, 10'h101);
        apply_stimulus('{x_m: 8'd0, y_m: 8'd16}, 16'h1111, lat, l, o);
        check_output("t3_latency", 32'(lat), 32'd29);
        check_output("t3_lines", 32'(l), 32'd4);
        check_output("t3_row16", 32'(mem[16]), 32'h011);
        check_output("t3_row19", 32'(mem[19]), 32'h088);
        check_output("t3_row4", 32'(mem[4]), 32'h200);
        check_output("t3_row7", 32'(mem[7]), 32'h101);
        check_output("t3_row0", 32'(mem[0]), 32'h000);
        check_output("t3_row3", 32'(mem[3]), 32'h000);

        $display("[TB] step 4: overflow above field");
        clear_field();
        base = wr_count;
        apply_stimulus('{x_m: 8'd3, y_m: 8'hFE}, 16'h1111, lat, l, o);
        check_output("t4_latency", 32'(lat), 32'd25);
        check_output("t4_ovf", 32'(o), 32'd1);
        check_output("t4_lines", 32'(l), 32'd0);
        check_output("t4_row0", 32'(mem[0]), 32'h008);
        check_output("t4_row1", 32'(mem[1]), 32'h008);
        check_output("t4_writes", 32'(wr_count - base), 32'd2);

        $display("[TB] step 4b: column clipping");
        clear_field();
        base = wr_count;
        apply_stimulus('{x_m: 8'd8, y_m: 8'd19}, 16'h00FF, lat, l, o);
        check_output("clip_r_row19", 32'(mem[19]), 32'h300);
        check_output("clip_r_writes", 32'(wr_count - base), 32'd1);
        check_output("clip_r_ovf", 32'(o), 32'd0);
        apply_stimulus('{x_m: 8'hFE, y_m: 8'd5}, 16'h000F, lat, l, o);
        check_output("clip_l_row5", 32'(mem[5]), 32'h003);
        check_output("clip_l_row6", 32'(mem[6]), 32'h000);

        $display("[TB] step 5a: start held during operation");
        clear_field();
        done_seen  = 0;
        first_done = -1;
        @(negedge clk);
        pos   = '{x_m: 8'd4, y_m: 8'd18};
        shape = 16'h0033;
        start = 1'b1;
        @(posedge clk);
        #1;
        pos   = '{x_m: 8'd0, y_m: 8'd0};
        shape = 16'hFFFF;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 20) start = 1'b0;
            if (done) begin
                done_seen++;
                if (first_done < 0) first_done = n;
            end
        end
        check_output("t5_done_count", 32'(done_seen), 32'd1);
        check_output("t5_latency", 32'(first_done), 32'd25);
        check_output("t5_row18", 32'(mem[18]), 32'h030);
        check_output("t5_row0", 32'(mem[0]), 32'h000);

        $display("[TB] step 5b: reset during merge");
        clear_field();
        @(negedge clk);
        pos   = '{x_m: 8'd2, y_m: 8'd0};
        shape = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("t5_rst_wr", 32'(row_wr), 32'd0);
        check_output("t5_rst_ready", 32'(ready), 32'd1);
        check_output("t5_rst_done", 32'(done), 32'd0);
        base = wr_count;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("t5_rst_no_done", 32'(done_seen), 32'd0);
        check_output("t5_rst_no_writes", 32'(wr_count - base), 32'd0);
        check_output("t5_rst_row0", 32'(mem[0]), 32'h004);
        check_output("t5_rst_row1", 32'(mem[1]), 32'h004);
        check_output("t5_rst_row3", 32'(mem[3]), 32'h000);

        $display("[TB] step 6: non-adjacent full rows");
        clear_field();
        load_row(19, 10'h3FF);
        load_row(18, 10'h155);
        load_row(17, 10'h3FF);
        load_row(16, 10'h0AA);
        load_row(15, 10'h111);
        apply_stimulus('{x_m: 8'd0, y_m: 8'd0}, 16'h0033, lat, l, o);
        check_output("t6_latency", 32'(lat), 32'd27);
        check_output("t6_lines", 32'(l), 32'd2);
        check_output("t6_row19", 32'(mem[19]), 32'h155);
        check_output("t6_row18", 32'(mem[18]), 32'h0AA);
        check_output("t6_row17", 32'(mem[17]), 32'h111);
        check_output("t6_row3", 32'(mem[3]), 32'h003);
        check_output("t6_row2", 32'(mem[2]), 32'h003);
        check_output("t6_row1", 32'(mem[1]), 32'h000);
        check_output("t6_row0", 32'(mem[0]), 32'h000);

        check_output("write_addr_range", 32'(bad_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
